stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 5_000_000, gives the number of clock cycles per counter tick (0.1 s at 50 MHz); legal range is 2 to 2^23.
REQ-002 i_Clk  input  1  is the single system clock; all state changes on its rising edge.
REQ-003 i_Rst  input  1  is the reset; it is asynchronous and active-high.
REQ-004 i_fStart  input  1  is the raw start/pause button, active-low and asynchronous to i_Clk.
REQ-005 i_fLap  input  1  is the raw lap/clear button, active-low and asynchronous to i_Clk.
REQ-006 i_Cnt  input  12  is the live 3-digit BCD count from the counter datapath (digit 0 in [3:0]).
REQ-007 o_Tick  output  1  is a one-cycle count-enable pulse to the counter datapath.
REQ-008 o_Clr  output  1  is the synchronous clear level to the counter datapath.
REQ-009 o_Disp  output  12  is the BCD value to be shown on the display.
REQ-010 o_LapValid  output  1  is high while o_Disp shows a frozen lap value.
REQ-011 o_State  output  2  is the current FSM state for debug.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer and a falling-edge detector, giving a one-cycle event per press.
REQ-013 For a press, the state register SHALL update on the 3rd rising edge counted from the first edge that samples the low level.
REQ-014 The FSM SHALL have the states IDLE=0, RUN=1, PAUSE=2 and LAP=3.
REQ-015 IDLE: a start event SHALL move the FSM to RUN, and a lap event SHALL be ignored.
REQ-016 RUN: a start event SHALL move the FSM to PAUSE, and a lap event SHALL move it to LAP while capturing i_Cnt into the lap register on the same edge.
REQ-017 LAP: a start event SHALL move the FSM to PAUSE, and a lap event SHALL move it to RUN.
REQ-018 PAUSE: a start event SHALL move the FSM to RUN, and a lap event SHALL move it to IDLE.
REQ-019 Simultaneous start and lap events SHALL act as start only; the lap event is discarded and the lap register is unchanged.
REQ-020 The prescaler SHALL be ceil(log2(TICK_DIV)) bits wide; in RUN and LAP it counts 0..TICK_DIV-1 and wraps to 0.
REQ-021 o_Tick SHALL be high for exactly the cycle in which the prescaler equals TICK_DIV-1 while in RUN or LAP.
REQ-022 In PAUSE, the prescaler SHALL hold its value, so that a resumed run keeps sub-tick phase.
REQ-023 In IDLE, the prescaler SHALL be 0, and the lap register SHALL be cleared on entry to IDLE.
REQ-024 o_Clr SHALL equal (state==IDLE), and o_LapValid SHALL equal (state==LAP).
REQ-025 o_Disp SHALL be the lap register when the state is LAP, and i_Cnt otherwise (combinational mux).
REQ-026 The FSM SHALL generate no tick in the cycle it enters RUN from IDLE; the first o_Tick occurs TICK_DIV cycles after entry.

Reset
REQ-027 Asserting i_Rst SHALL immediately force the following, with no clock required: state IDLE, prescaler 0, lap register 0, and synchronizer/edge flops 1 (button released).
REQ-028 During reset, the outputs SHALL be o_Tick=0, o_Clr=1, o_LapValid=0, o_State=0 and o_Disp=i_Cnt.
REQ-029 A button held low across reset release SHALL produce no event until it is released and pressed again.

Structure
REQ-030 The state encodings, the BCD width (12) and the TICK_DIV default SHALL live in a shared package, stopwatch_pkg.
REQ-031 The synchronizer and edge detector SHALL be one sub-module, btn_edge, instantiated twice.

Verification (TICK_DIV=4)
REQ-032 Reset test: assert i_Rst mid-RUN with no clock toggling -> o_State=0, o_Clr=1 and o_Tick=0 immediately.
REQ-033 Start test: press start in IDLE -> o_State=1 at the 3rd edge, then o_Tick pulses at cycles 4, 8 and 12 after entry.
REQ-034 Lap test: in RUN with i_Cnt=12'h123, press lap, then drive i_Cnt=12'h124 -> o_Disp stays 12'h123, o_LapValid=1 and ticks continue; a second lap -> o_Disp=12'h124.
REQ-035 Pause test: press start in RUN when the prescaler is 2 -> no tick in PAUSE; press start again -> first o_Tick 2 cycles after re-entering RUN.
REQ-036 Simultaneous-press test: start and lap pressed simultaneously in RUN -> o_State=2 and the lap register is unchanged.
REQ-037 Clear test: press lap in PAUSE -> o_State=0 and o_Clr=1; a subsequent lap press in IDLE -> no state change.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
// Imported by btn_edge and stopwatch_ctrl.
package stopwatch_pkg;

  localparam int BCD_W        = 12;
  localparam int TICK_DIV_DEF = 5_000_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } sw_state_e;

endpackage

// File: rtl/stopwatch_btn_edge.sv
// Button conditioner: 2-flop synchronizer plus falling-edge detector.
// Gives one event per press of an active-low raw button.
module btn_edge
  import stopwatch_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_evt
);

  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       prev_q, prev_d;
  logic       arm_q, arm_d;
  logic [1:0] vld_q, vld_d;

  // Arm only after a genuine released level has reached s2, so a
  // button held through reset cannot fire on release of reset.
  always_comb begin
    s1_d   = i_btn_n;
    s2_d   = s1_q;
    prev_d = s2_q;
    vld_d  = {vld_q[0], 1'b1};
    arm_d  = arm_q | (vld_q[1] & s2_q);
    o_evt  = arm_q & prev_q & ~s2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
      vld_q  <= 2'b00;
      arm_q  <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      vld_q  <= vld_d;
      arm_q  <= arm_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button events, run/pause/lap FSM,
// tick prescaler and lap capture register.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_fStart,
  input  logic             i_fLap,
  input  logic [BCD_W-1:0] i_Cnt,
  output logic             o_Tick,
  output logic             o_Clr,
  output logic [BCD_W-1:0] o_Disp,
  output logic             o_LapValid,
  output logic [1:0]       o_State
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE = PW'(1);

  sw_state_e        state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [BCD_W-1:0] lap_q, lap_d;
  logic             start_ev, lap_ev;
  logic             running;

  btn_edge u_start (
    .clk     (i_Clk),
    .rst     (i_Rst),
    .i_btn_n (i_fStart),
    .o_evt   (start_ev)
  );

  btn_edge u_lap (
    .clk     (i_Clk),
    .rst     (i_Rst),
    .i_btn_n (i_fLap),
    .o_evt   (lap_ev)
  );

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    lap_d   = lap_q;
    running = (state_q == ST_RUN) ||
              (state_q == ST_LAP);

    // Start has priority; a lap event alongside it is dropped.
    unique case (state_q)
      ST_IDLE: begin
        if (start_ev) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start_ev) begin
          state_d = ST_PAUSE;
        end else if (lap_ev) begin
          state_d = ST_LAP;
          lap_d   = i_Cnt;
        end
      end
      ST_LAP: begin
        if (start_ev)    state_d = ST_PAUSE;
        else if (lap_ev) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (start_ev)    state_d = ST_RUN;
        else if (lap_ev) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q == ST_IDLE) begin
      pre_d = '0;
    end else if (running) begin
      pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PRE_ONE;
    end

    if (state_d == ST_IDLE) lap_d = '0;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      lap_q   <= lap_d;
    end
  end

  assign o_Tick     = running && (pre_q == PRE_MAX);
  assign o_Clr      = (state_q == ST_IDLE);
  assign o_LapValid = (state_q == ST_LAP);
  assign o_Disp     = (state_q == ST_LAP) ? lap_q : i_Cnt;
  assign o_State    = state_q;

endmodule
